// File: rtl/board_controller.sv
// board_controller
//   Game-state writer for the tic-tac-toe datapath. It turns debounced button
//   pulses into the board vector and the highlight vector that the VGA tile
//   renderer uses. It also owns the cursor, turn alternation, cursor
//   blink/preview, win/draw detection and new-game restart.
//
// Ports
//   clk        system clock
//   reset      synchronous, active-low reset
//   btn_up/down/left/right  single-cycle cursor move pulses (wrap in row/col)
//   btn_sel    place current player's mark at the cursor
//   btn_new    clear the board and start a new game
//   tiles      per tile k: [2k] occupied/visible, [2k+1] shape (1 = O, 0 = X)
//   color      per tile k: 1 = red, 0 = white
//   cursor     cursor tile index 0..8 (k = row*3 + col)
//   turn       player to move: 0 = X, 1 = O
//   winner     00 none, 01 X, 10 O, 11 draw
//   game_over  high in WIN and DRAW
//
// State  | meaning
// -------+-------------------------------------------------------------
// PLAY   | accepting moves and selections; cursor blinks, preview shown
// CHECK  | one cycle scoring the mark just placed for the player in turn
// WIN    | line completed; winning lines shown red until a new game
// DRAW   | board full with no line; waits for a new game

module board_controller #(
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_sel,
  input  logic        btn_new,
  output logic [17:0] tiles,
  output logic [8:0]  color,
  output logic [3:0]  cursor,
  output logic        turn,
  output logic [1:0]  winner,
  output logic        game_over
);

  localparam int CW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);

  // Bit masks of the eight scoring lines over tile indices.
  localparam logic [7:0][8:0] LINES = {
    9'b001_010_100,   // anti-diagonal 2,4,6
    9'b100_010_001,   // diagonal 0,4,8
    9'b100_100_100,   // column 2
    9'b010_010_010,   // column 1
    9'b001_001_001,   // column 0
    9'b111_000_000,   // row 2
    9'b000_111_000,   // row 1
    9'b000_000_111    // row 0
  };

  typedef enum logic [1:0] {
    S_PLAY,
    S_CHECK,
    S_WIN,
    S_DRAW
  } state_t;

  state_t        state_q, state_d;
  logic [8:0]    occ_q, occ_d;
  logic [8:0]    shape_q, shape_d;
  logic [8:0]    win_mask_q, win_mask_d;
  logic [3:0]    cursor_q, cursor_d;
  logic          turn_q, turn_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;

  logic [8:0]    cursor_hot;
  logic [8:0]    mine;
  logic [8:0]    hit;
  logic [1:0]    row, col;
  logic [3:0]    cursor_moved;
  logic          any_move;

  assign cursor_hot = 9'd1 << cursor_q;
  assign mine       = occ_q & (turn_q ? shape_q : ~shape_q);
  assign any_move   = btn_up | btn_down | btn_left | btn_right;

  always_comb begin
    row = 2'd0;
    col = 2'd0;
    case (cursor_q)
      4'd0: begin row = 2'd0; col = 2'd0; end
      4'd1: begin row = 2'd0; col = 2'd1; end
      4'd2: begin row = 2'd0; col = 2'd2; end
      4'd3: begin row = 2'd1; col = 2'd0; end
      4'd4: begin row = 2'd1; col = 2'd1; end
      4'd5: begin row = 2'd1; col = 2'd2; end
      4'd6: begin row = 2'd2; col = 2'd0; end
      4'd7: begin row = 2'd2; col = 2'd1; end
      4'd8: begin row = 2'd2; col = 2'd2; end
      default: begin row = 2'd0; col = 2'd0; end
    endcase
  end

  // Move priority up > down > left > right; wrapping stays in the row/column.
  always_comb begin
    cursor_moved = cursor_q;
    if (btn_up)
      cursor_moved = (row == 2'd0) ? cursor_q + 4'd6 : cursor_q - 4'd3;
    else if (btn_down)
      cursor_moved = (row == 2'd2) ? cursor_q - 4'd6 : cursor_q + 4'd3;
    else if (btn_left)
      cursor_moved = (col == 2'd0) ? cursor_q + 4'd2 : cursor_q - 4'd1;
    else if (btn_right)
      cursor_moved = (col == 2'd2) ? cursor_q - 4'd2 : cursor_q + 4'd1;
  end

  // OR of every completed line, so a double win highlights both lines.
  always_comb begin
    hit = '0;
    for (int i = 0; i < 8; i++) begin
      if ((mine & LINES[i]) == LINES[i])
        hit = hit | LINES[i];
    end
  end

  always_comb begin
    state_d    = state_q;
    occ_d      = occ_q;
    shape_d    = shape_q;
    win_mask_d = win_mask_q;
    cursor_d   = cursor_q;
    turn_d     = turn_q;
    cnt_d      = cnt_q + 1'b1;
    phase_d    = phase_q;

    if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end

    if (btn_new) begin
      state_d    = S_PLAY;
      occ_d      = '0;
      shape_d    = '0;
      win_mask_d = '0;
      cursor_d   = 4'd4;
      turn_d     = 1'b0;
      cnt_d      = '0;
      phase_d    = 1'b0;
    end else begin
      case (state_q)
        S_PLAY: begin
          if (btn_sel) begin
            // A select on an occupied tile is swallowed, not passed to moves.
            if ((occ_q & cursor_hot) == 9'd0) begin
              occ_d   = occ_q | cursor_hot;
              shape_d = turn_q ? (shape_q | cursor_hot) : (shape_q & ~cursor_hot);
              state_d = S_CHECK;
            end
          end else if (any_move) begin
            cursor_d = cursor_moved;
            cnt_d    = '0;
            phase_d  = 1'b1;
          end
        end
        S_CHECK: begin
          if (hit != 9'd0) begin
            win_mask_d = hit;
            state_d    = S_WIN;
          end else if (&occ_q) begin
            state_d = S_DRAW;
          end else begin
            turn_d  = ~turn_q;
            state_d = S_PLAY;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_PLAY;
      occ_q      <= '0;
      shape_q    <= '0;
      win_mask_q <= '0;
      cursor_q   <= 4'd4;
      turn_q     <= 1'b0;
      cnt_q      <= '0;
      phase_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      occ_q      <= occ_d;
      shape_q    <= shape_d;
      win_mask_q <= win_mask_d;
      cursor_q   <= cursor_d;
      turn_q     <= turn_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
    end
  end

  logic [8:0] preview_hot;
  logic [8:0] vis;
  logic [8:0] shp;

  // The preview is the mover's mark blinking on an empty cursor tile.
  assign preview_hot = cursor_hot & ~occ_q & {9{phase_q && (state_q == S_PLAY)}};
  assign vis         = occ_q | preview_hot;
  assign shp         = (shape_q & occ_q) | (preview_hot & {9{turn_q}});

  always_comb begin
    tiles = '0;
    for (int k = 0; k < 9; k++) begin
      tiles[2*k]     = vis[k];
      tiles[2*k + 1] = shp[k];
    end
  end

  always_comb begin
    color     = '0;
    winner    = 2'b00;
    game_over = 1'b0;
    case (state_q)
      S_PLAY, S_CHECK: color = cursor_hot & {9{phase_q}};
      S_WIN: begin
        color     = win_mask_q;
        winner    = {turn_q, ~turn_q};
        game_over = 1'b1;
      end
      S_DRAW: begin
        winner    = 2'b11;
        game_over = 1'b1;
      end
      default: ;
    endcase
  end

  assign cursor = cursor_q;
  assign turn   = turn_q;

endmodule

// File: tb/tb_board_controller.sv
module tb_board_controller;

  localparam int BLINK_DIV = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic        btn_sel = 1'b0, btn_new = 1'b0;
  logic [17:0] tiles;
  logic [8:0]  color;
  logic [3:0]  cursor;
  logic        turn;
  logic [1:0]  winner;
  logic        game_over;

  int checks = 0;
  int errors = 0;

  board_controller #(.BLINK_DIV(BLINK_DIV)) dut (
    .clk(clk), .reset(reset),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .btn_sel(btn_sel), .btn_new(btn_new),
    .tiles(tiles), .color(color), .cursor(cursor), .turn(turn),
    .winner(winner), .game_over(game_over)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: board cells hold 0 empty, 1 X, 2 O.
  // Stage: 0 playing, 1 scoring, 2 won, 3 drawn.
  int         m_board[9];
  int         m_r, m_c, m_turn, m_cnt, m_phase, m_stage;
  logic [8:0] m_mask;

  logic [17:0] exp_tiles;
  logic [8:0]  exp_color;
  logic [3:0]  exp_cursor;
  logic        exp_turn;
  logic [1:0]  exp_winner;
  logic        exp_over;

  task automatic model_clear();
    for (int k = 0; k < 9; k++) m_board[k] = 0;
    m_r = 1; m_c = 1; m_turn = 0; m_cnt = 0; m_phase = 0; m_stage = 0; m_mask = '0;
  endtask

  function automatic logic [8:0] line_bits(int a, int b, int c, int p);
    logic [8:0] r;
    r = '0;
    if (m_board[a] == p && m_board[b] == p && m_board[c] == p) begin
      r[a] = 1'b1; r[b] = 1'b1; r[c] = 1'b1;
    end
    return r;
  endfunction

  // b = {new, sel, up, down, left, right}
  task automatic model_step(input logic rst_n, input logic [5:0] b);
    logic [8:0] mask;
    int p, k, full;
    if (!rst_n || b[5]) begin
      model_clear();
    end else begin
      if (m_cnt == BLINK_DIV - 1) begin m_cnt = 0; m_phase = 1 - m_phase; end
      else m_cnt = m_cnt + 1;
      case (m_stage)
        0: begin
          if (b[4]) begin
            k = m_r * 3 + m_c;
            if (m_board[k] == 0) begin m_board[k] = m_turn + 1; m_stage = 1; end
          end else if (b[3:0] != 4'b0) begin
            if (b[3])      m_r = (m_r + 2) % 3;
            else if (b[2]) m_r = (m_r + 1) % 3;
            else if (b[1]) m_c = (m_c + 2) % 3;
            else           m_c = (m_c + 1) % 3;
            m_cnt = 0; m_phase = 1;
          end
        end
        1: begin
          p = m_turn + 1;
          mask = '0;
          for (int i = 0; i < 3; i++) begin
            mask = mask | line_bits(3*i, 3*i + 1, 3*i + 2, p);
            mask = mask | line_bits(i, i + 3, i + 6, p);
          end
          mask = mask | line_bits(0, 4, 8, p);
          mask = mask | line_bits(2, 4, 6, p);
          full = 1;
          for (int j = 0; j < 9; j++) if (m_board[j] == 0) full = 0;
          if (mask != 0) begin m_mask = mask; m_stage = 2; end
          else if (full == 1) m_stage = 3;
          else begin m_turn = 1 - m_turn; m_stage = 0; end
        end
        default: ;
      endcase
    end
  endtask

  task automatic model_outputs();
    int ck;
    ck = m_r * 3 + m_c;
    exp_tiles = '0;
    exp_color = '0;
    for (int k = 0; k < 9; k++) begin
      if (m_board[k] != 0) begin
        exp_tiles[2*k] = 1'b1;
        exp_tiles[2*k + 1] = (m_board[k] == 2);
      end else if (m_stage == 0 && m_phase == 1 && k == ck) begin
        exp_tiles[2*k] = 1'b1;
        exp_tiles[2*k + 1] = (m_turn == 1);
      end
    end
    if (m_stage <= 1 && m_phase == 1) exp_color[ck] = 1'b1;
    if (m_stage == 2) exp_color = m_mask;
    exp_cursor = 4'(ck);
    exp_turn   = (m_turn == 1);
    exp_winner = (m_stage == 2) ? 2'(m_turn + 1) : (m_stage == 3) ? 2'b11 : 2'b00;
    exp_over   = (m_stage >= 2);
  endtask

  task automatic tick(input logic rst_n, input logic [5:0] b);
    reset = rst_n;
    {btn_new, btn_sel, btn_up, btn_down, btn_left, btn_right} = b;
    @(posedge clk);
    model_step(rst_n, b);
    #1;
    reset = 1'b1;
    {btn_new, btn_sel, btn_up, btn_down, btn_left, btn_right} = 6'b0;
  endtask

  localparam logic [5:0] B_NONE = 6'b000000, B_NEW = 6'b100000, B_SEL = 6'b010000;
  localparam logic [5:0] B_UP = 6'b001000, B_DOWN = 6'b000100;
  localparam logic [5:0] B_LEFT = 6'b000010, B_RIGHT = 6'b000001;

  task automatic goto_tile(input int k);
    while (m_c != k % 3) tick(1'b1, B_RIGHT);
    while (m_r != k / 3) tick(1'b1, B_DOWN);
  endtask

  task automatic place(input int k);
    goto_tile(k);
    tick(1'b1, B_SEL);
    tick(1'b1, B_NONE);
  endtask

  task automatic test_reset();
    tick(1'b0, B_NONE);
    checks++; if (tiles !== 18'h0) begin errors++; $display("FAIL reset_tiles: got %h want 0", tiles); end
    checks++; if (color !== 9'h0) begin errors++; $display("FAIL reset_color: got %h want 0", color); end
    checks++; if (cursor !== 4'd4) begin errors++; $display("FAIL reset_cursor: got %0d want 4", cursor); end
    checks++; if (turn !== 1'b0) begin errors++; $display("FAIL reset_turn: got %b want 0", turn); end
    checks++; if (winner !== 2'b00) begin errors++; $display("FAIL reset_winner: got %b want 00", winner); end
    checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL reset_over: got %b want 0", game_over); end
  endtask

  task automatic test_blink();
    for (int i = 0; i < 4; i++) tick(1'b1, B_NONE);
    checks++; if (tiles[9:8] !== 2'b01) begin errors++; $display("FAIL blink_on_tiles: got %b want 01", tiles[9:8]); end
    checks++; if (color[4] !== 1'b1) begin errors++; $display("FAIL blink_on_color: got %b want 1", color[4]); end
    for (int i = 0; i < 4; i++) tick(1'b1, B_NONE);
    checks++; if (tiles[9:8] !== 2'b00) begin errors++; $display("FAIL blink_off_tiles: got %b want 00", tiles[9:8]); end
    checks++; if (color[4] !== 1'b0) begin errors++; $display("FAIL blink_off_color: got %b want 0", color[4]); end
  endtask

  task automatic test_wrap();
    logic [5:0] seq[5];
    int         want[5];
    seq  = '{B_LEFT, B_LEFT, B_UP, B_UP, B_RIGHT};
    want = '{3, 5, 2, 8, 6};
    tick(1'b0, B_NONE);
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, seq[i]);
      checks++;
      if (cursor !== 4'(want[i])) begin
        errors++; $display("FAIL wrap_step%0d: got %0d want %0d", i, cursor, want[i]);
      end
    end
  endtask

  task automatic test_x_win();
    tick(1'b0, B_NONE);
    place(0); place(3); place(1); place(4);
    goto_tile(2);
    tick(1'b1, B_SEL);
    checks++; if (tiles[5:0] !== 6'b010101) begin errors++; $display("FAIL win_tiles: got %b want 010101", tiles[5:0]); end
    checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL win_early_over: got %b want 0", game_over); end
    tick(1'b1, B_NONE);
    checks++; if (winner !== 2'b01) begin errors++; $display("FAIL win_winner: got %b want 01", winner); end
    checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL win_over: got %b want 1", game_over); end
    checks++; if (color !== 9'b000000111) begin errors++; $display("FAIL win_color: got %b want 000000111", color); end
    tick(1'b1, B_LEFT); tick(1'b1, B_UP); tick(1'b1, B_SEL); tick(1'b1, B_SEL);
    checks++; if (tiles !== 18'h003D5) begin errors++; $display("FAIL win_frozen_tiles: got %h want 003d5", tiles); end
    checks++; if (cursor !== 4'd2) begin errors++; $display("FAIL win_frozen_cursor: got %0d want 2", cursor); end
    checks++; if (turn !== 1'b0) begin errors++; $display("FAIL win_frozen_turn: got %b want 0", turn); end
    checks++; if (winner !== 2'b01) begin errors++; $display("FAIL win_frozen_winner: got %b want 01", winner); end
  endtask

  task automatic test_occupied();
    tick(1'b0, B_NONE);
    place(4);
    tick(1'b1, B_SEL);
    checks++; if (turn !== 1'b1) begin errors++; $display("FAIL occ_turn: got %b want 1", turn); end
    checks++; if (tiles !== 18'h00100) begin errors++; $display("FAIL occ_tiles: got %h want 00100", tiles); end
    tick(1'b1, B_LEFT);
    checks++; if (cursor !== 4'd3) begin errors++; $display("FAIL occ_still_play: got %0d want 3", cursor); end
    tick(1'b1, B_SEL | B_LEFT);
    checks++; if (tiles[7:6] !== 2'b11) begin errors++; $display("FAIL sel_left_mark: got %b want 11", tiles[7:6]); end
    checks++; if (cursor !== 4'd3) begin errors++; $display("FAIL sel_left_cursor: got %0d want 3", cursor); end
  endtask

  task automatic test_draw();
    int   seq[9];
    logic evens;
    seq = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    tick(1'b0, B_NONE);
    for (int i = 0; i < 9; i++) place(seq[i]);
    evens = 1'b1;
    for (int k = 0; k < 9; k++) evens = evens & tiles[2*k];
    checks++; if (winner !== 2'b11) begin errors++; $display("FAIL draw_winner: got %b want 11", winner); end
    checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL draw_over: got %b want 1", game_over); end
    checks++; if (color !== 9'h0) begin errors++; $display("FAIL draw_color: got %b want 0", color); end
    checks++; if (evens !== 1'b1) begin errors++; $display("FAIL draw_occupied: got %h want all even bits 1", tiles); end
  endtask

  task automatic test_restart();
    tick(1'b0, B_NONE);
    place(0);
    tick(1'b1, B_RIGHT);
    tick(1'b1, B_NEW | B_SEL);
    checks++; if (tiles !== 18'h0) begin errors++; $display("FAIL new_tiles: got %h want 0", tiles); end
    checks++; if (cursor !== 4'd4) begin errors++; $display("FAIL new_cursor: got %0d want 4", cursor); end
    checks++; if (turn !== 1'b0) begin errors++; $display("FAIL new_turn: got %b want 0", turn); end
    tick(1'b1, B_SEL);
    tick(1'b0, B_NONE);
    checks++; if (tiles !== 18'h0) begin errors++; $display("FAIL rst_check_tiles: got %h want 0", tiles); end
    checks++; if (winner !== 2'b00) begin errors++; $display("FAIL rst_check_winner: got %b want 00", winner); end
    checks++; if (cursor !== 4'd4) begin errors++; $display("FAIL rst_check_cursor: got %0d want 4", cursor); end
    checks++; if (turn !== 1'b0) begin errors++; $display("FAIL rst_check_turn: got %b want 0", turn); end
  endtask

  task automatic test_random();
    logic [5:0] b;
    logic       rst_n;
    tick(1'b0, B_NONE);
    for (int n = 0; n < 4000; n++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      b[5] = ($urandom_range(0, 79) == 0);
      b[4] = ($urandom_range(0, 2) == 0);
      for (int i = 0; i < 4; i++) b[i] = ($urandom_range(0, 3) == 0);
      tick(rst_n, b);
      model_outputs();
      checks++; if (tiles !== exp_tiles) begin errors++; $display("FAIL rnd_tiles@%0d: got %h want %h", n, tiles, exp_tiles); end
      if (m_stage != 1) begin
        checks++; if (color !== exp_color) begin errors++; $display("FAIL rnd_color@%0d: got %b want %b", n, color, exp_color); end
      end
      checks++; if (cursor !== exp_cursor) begin errors++; $display("FAIL rnd_cursor@%0d: got %0d want %0d", n, cursor, exp_cursor); end
      checks++; if (turn !== exp_turn) begin errors++; $display("FAIL rnd_turn@%0d: got %b want %b", n, turn, exp_turn); end
      checks++; if (winner !== exp_winner) begin errors++; $display("FAIL rnd_winner@%0d: got %b want %b", n, winner, exp_winner); end
      checks++; if (game_over !== exp_over) begin errors++; $display("FAIL rnd_over@%0d: got %b want %b", n, game_over, exp_over); end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_blink();
    test_wrap();
    test_x_win();
    test_occupied();
    test_draw();
    test_restart();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
